// File: rtl/pattern_pkg.sv
// Shared types and default sizing for the pattern window counter.
package pattern_pkg;

    typedef enum logic {IDLE, RUN} wstate_t;

    localparam int unsigned DefaultWindow = 16;
    localparam int unsigned DefaultCntW   = 8;

endpackage

// File: rtl/window_timer.sv
// Window position counter: counts run cycles 0..WINDOW-1 and flags the last cycle of each window.
module window_timer #(
    parameter int unsigned WINDOW = 16
) (
    input  logic clk,
    input  logic reset,
    input  logic run,
    input  logic clr,
    output logic win_end
);
    localparam int unsigned CntW = (WINDOW > 2) ? $clog2(WINDOW) : 1;
    localparam logic [CntW-1:0] LastCnt = CntW'(WINDOW - 1);

    logic [CntW-1:0] win_cnt_q, win_cnt_d;

    assign win_end = run && (win_cnt_q == LastCnt);

    // Any cycle that is not a sample restarts the window, so partial windows never resume.
    always_comb begin
        win_cnt_d = win_cnt_q;
        if (clr || !run || win_end) begin
            win_cnt_d = '0;
        end else begin
            win_cnt_d = win_cnt_q + CntW'(1);
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            win_cnt_q <= '0;
        end else begin
            win_cnt_q <= win_cnt_d;
        end
    end

endmodule

// File: rtl/pattern_window_counter.sv
// Counts detector pulses over WINDOW-cycle windows and publishes each count via valid/ready.
// Define PATTERN_CNT_SAT_EN for a saturating accumulator; otherwise it wraps.
module pattern_window_counter
    import pattern_pkg::*;
#(
    parameter int unsigned WINDOW = DefaultWindow,
    parameter int unsigned CNT_W  = DefaultCntW
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic             clr,
    input  logic             det,
    input  logic             out_ready,
    output logic             out_valid,
    output logic [CNT_W-1:0] out_count,
    output logic             overrun,
    output logic             busy
);
    wstate_t          state_q, state_d;
    logic             run;
    logic             win_end;
    logic             handshake;
    logic [CNT_W-1:0] acc_q, acc_d;
    logic [CNT_W-1:0] result;
    logic             out_valid_q, out_valid_d;
    logic [CNT_W-1:0] out_count_q, out_count_d;
    logic             overrun_q, overrun_d;

    // A sample is taken only on RUN cycles that stay in RUN; the leaving edge discards.
    assign busy = (state_q == RUN);
    assign run  = busy && en;

    window_timer #(
        .WINDOW (WINDOW)
    ) u_window_timer (
        .clk     (clk),
        .reset   (reset),
        .run     (run),
        .clr     (clr),
        .win_end (win_end)
    );

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: if (en)  state_d = RUN;
            RUN:  if (!en) state_d = IDLE;
        endcase
    end

    // Accumulated count including the current sample.
    always_comb begin
`ifdef PATTERN_CNT_SAT_EN
        if (acc_q == {CNT_W{1'b1}}) begin
            result = acc_q;
        end else begin
            result = acc_q + CNT_W'(det);
        end
`else
        result = acc_q + CNT_W'(det);
`endif
    end

    always_comb begin
        acc_d = acc_q;
        if (clr || !run || win_end) begin
            acc_d = '0;
        end else begin
            acc_d = result;
        end
    end

    always_comb begin
        out_valid_d = out_valid_q;
        out_count_d = out_count_q;
        overrun_d   = overrun_q;
        handshake   = out_valid_q && out_ready;
        if (clr) begin
            out_valid_d = 1'b0;
            out_count_d = '0;
            overrun_d   = 1'b0;
        end else if (win_end) begin
            if (!out_valid_q || handshake) begin
                out_valid_d = 1'b1;
                out_count_d = result;
            end else begin
                // Pending result not yet taken: keep it, drop the new one.
                overrun_d = 1'b1;
            end
        end else if (handshake) begin
            out_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= IDLE;
            acc_q       <= '0;
            out_valid_q <= 1'b0;
            out_count_q <= '0;
            overrun_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            acc_q       <= acc_d;
            out_valid_q <= out_valid_d;
            out_count_q <= out_count_d;
            overrun_q   <= overrun_d;
        end
    end

    assign out_valid = out_valid_q;
    assign out_count = out_count_q;
    assign overrun   = overrun_q;

endmodule

// File: tb/tb_pattern_window_counter.sv
// Bench for pattern_window_counter: queue-based window model plus directed windows.
module tb_pattern_window_counter;

    localparam int unsigned WINDOW = 16;

    logic       clk = 1'b0;
    logic       reset;
    logic       en, clr, det, out_ready;
    logic       out_valid, overrun, busy;
    logic [7:0] out_count;
    logic       out_valid_s, overrun_s, busy_s;
    logic [2:0] out_count_s;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    pattern_window_counter #(
        .WINDOW (WINDOW),
        .CNT_W  (8)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .en        (en),
        .clr       (clr),
        .det       (det),
        .out_ready (out_ready),
        .out_valid (out_valid),
        .out_count (out_count),
        .overrun   (overrun),
        .busy      (busy)
    );

    pattern_window_counter #(
        .WINDOW (WINDOW),
        .CNT_W  (3)
    ) dut_s (
        .clk       (clk),
        .reset     (reset),
        .en        (en),
        .clr       (clr),
        .det       (det),
        .out_ready (out_ready),
        .out_valid (out_valid_s),
        .out_count (out_count_s),
        .overrun   (overrun_s),
        .busy      (busy_s)
    );

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d at %0t", name, got, exp, $time);
        end
    endtask

    // Count of a 3-bit result for a window sum s.
    function automatic int small_of(input int s);
`ifdef PATTERN_CNT_SAT_EN
        return (s > 7) ? 7 : s;
`else
        return s % 8;
`endif
    endfunction

    // Model: the window is the list of samples taken since it started.
    bit m_run, m_valid, m_ovr, m_hs, m_wend;
    int m_big, m_small, m_sum;
    bit win_q[$];

    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            win_q.delete();
            m_run = 0; m_valid = 0; m_ovr = 0; m_big = 0; m_small = 0;
        end else begin
            m_hs   = m_valid && out_ready;
            m_wend = 0;
            if (clr) begin
                win_q.delete();
                m_valid = 0; m_ovr = 0; m_big = 0; m_small = 0;
            end else begin
                if (m_run && en) begin
                    win_q.push_back(det);
                    if (win_q.size() == WINDOW) begin
                        m_wend = 1;
                        m_sum  = 0;
                        foreach (win_q[i]) m_sum += int'(win_q[i]);
                        win_q.delete();
                    end
                end else begin
                    win_q.delete();
                end
                if (m_wend) begin
                    if (!m_valid || m_hs) begin
                        m_valid = 1; m_big = m_sum % 256; m_small = small_of(m_sum);
                    end else begin
                        m_ovr = 1;
                    end
                end else if (m_hs) begin
                    m_valid = 0;
                end
            end
            m_run = en;
        end
    end

    always @(negedge clk) begin
        chk("busy", busy, m_run);
        chk("out_valid", out_valid, m_valid);
        chk("out_count", out_count, m_big);
        chk("overrun", overrun, m_ovr);
        chk("busy_s", busy_s, m_run);
        chk("out_valid_s", out_valid_s, m_valid);
        chk("out_count_s", out_count_s, m_small);
        chk("overrun_s", overrun_s, m_ovr);
    end

    task automatic cycle();
        @(posedge clk);
        #2;
    endtask

    // Drive the first n samples of pat (bit i = sample i); optionally ready on the last one.
    task automatic run_window(input logic [15:0] pat, input int n, input bit rdy_last);
        for (int i = 0; i < n; i++) begin
            det = pat[i];
            if (rdy_last && i == n - 1) out_ready = 1'b1;
            cycle();
        end
        det = 1'b0;
        if (rdy_last) out_ready = 1'b0;
    endtask

    initial begin
        reset = 1'b0; en = 1'b0; clr = 1'b0; det = 1'b0; out_ready = 1'b0;
        #1;
        chk("reset out_valid", out_valid, 0);
        chk("reset out_count", out_count, 0);
        chk("reset overrun", overrun, 0);
        chk("reset busy", busy, 0);
        cycle();
        reset = 1'b1;
        cycle();

        // Window 1: five detections including the last sample.
        en = 1'b1;
        cycle();
        run_window(16'h8095, 16, 0);
        chk("w1 out_valid", out_valid, 1);
        chk("w1 out_count", out_count, 5);
        chk("w1 busy", busy, 1);

        // Window 2 ends with the result still pending.
        run_window(16'h0111, 16, 0);
        chk("w2 out_count held", out_count, 5);
        chk("w2 overrun", overrun, 1);
        out_ready = 1'b1;
        cycle();
        out_ready = 1'b0;
        chk("hs out_valid", out_valid, 0);
        chk("hs overrun sticky", overrun, 1);

        clr = 1'b1;
        cycle();
        clr = 1'b0;
        chk("clr overrun", overrun, 0);
        chk("clr out_valid", out_valid, 0);
        chk("clr out_count", out_count, 0);

        // Count 7 pending, then count 2 arrives with ready on the same edge.
        run_window(16'h803F, 16, 0);
        chk("wa out_count", out_count, 7);
        run_window(16'h8001, 16, 1);
        chk("wb out_count", out_count, 2);
        chk("wb out_valid", out_valid, 1);
        chk("wb overrun", overrun, 0);

        // Handshake takes one sample slot; 9 more make a 10-sample partial with 4 hits.
        out_ready = 1'b1;
        cycle();
        out_ready = 1'b0;
        chk("drain out_valid", out_valid, 0);
        run_window(16'h0055, 9, 0);
        en = 1'b0;
        cycle();
        chk("idle busy", busy, 0);
        cycle();
        cycle();
        chk("partial dropped", out_valid, 0);
        en = 1'b1;
        cycle();
        run_window(16'h8001, 16, 0);
        chk("restart out_count", out_count, 2);
        chk("restart out_valid", out_valid, 1);

        // Full window of detections: overflows the 3-bit instance.
        out_ready = 1'b1;
        run_window(16'hFFFF, 16, 0);
        out_ready = 1'b0;
        chk("full out_count", out_count, 16);
`ifdef PATTERN_CNT_SAT_EN
        chk("full out_count_s", out_count_s, 7);
`else
        chk("full out_count_s", out_count_s, 0);
`endif

        // Asynchronous reset mid-window with a pending result.
        run_window(16'h001F, 5, 0);
        reset = 1'b0;
        #1;
        chk("areset out_valid", out_valid, 0);
        chk("areset out_count", out_count, 0);
        chk("areset overrun", overrun, 0);
        chk("areset busy", busy, 0);
        cycle();
        reset = 1'b1;
        cycle();
        run_window(16'h0F0F, 16, 0);
        chk("post reset out_count", out_count, 8);
        cycle();
        cycle();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete, expected completion");
        $fatal(1);
    end

endmodule
